// File: rtl/rom_burst_ctrl.sv
// rom_burst_ctrl: arbitrates burst-read commands from two requesters and streams tagged ROM data back.
// Define ROM_BURST_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module rom_burst_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_base,
   input  logic [LEN_W-1:0]  req0_len,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_base,
   input  logic [LEN_W-1:0]  req1_len,
   output logic              rom_read,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_id,
   output logic              rd_last,
   output logic              cmd_done,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [LEN_W-1:0]  remain;
   logic              owner;
   logic              grant0;
   logic              grant1;
   logic              accept;
   logic [ADDR_W-1:0] sel_base;
   logic [LEN_W-1:0]  sel_len;

`ifdef ROM_BURST_FIXED_PRIO_EN
   assign grant0 = req0_valid;
`else
   // Pointer holds the requester served last; requester 0 wins a tie unless it was served last.
   logic last_served;

   assign grant0 = req0_valid && (!req1_valid || last_served);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_served <= 1'b1;
      end else if (accept) begin
         last_served <= req1_ready;
      end
   end
`endif

   assign grant1   = req1_valid && !grant0;
   assign sel_base = grant0 ? req0_base : req1_base;
   assign sel_len  = grant0 ? req0_len : req1_len;
   assign accept   = req0_ready || req1_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rom_read   = 1'b0;
      cmd_done   = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (!rst) begin
               req0_ready = grant0;
               req1_ready = grant1;
               if (grant0 || grant1) begin
                  state_next = (sel_len == '0) ? DRAIN : ISSUE;
               end
            end
         end
         ISSUE: begin
            rom_read = 1'b1;
            busy     = 1'b1;
            if (remain == '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            cmd_done   = 1'b1;
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The ROM registers its output on a read edge, so the beat is valid exactly one cycle after each read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr <= '0;
         remain   <= '0;
         owner    <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rom_read;
         if (accept) begin
            owner <= req1_ready;
            if (sel_len != '0) begin
               rom_addr <= sel_base;
               remain   <= sel_len - LEN_W'(1);
            end
         end else if (rom_read && (remain != '0)) begin
            remain   <= remain - LEN_W'(1);
            rom_addr <= rom_addr + ADDR_W'(1);
         end
      end
   end

   assign rd_data = rd_valid ? rom_dout : '0;
   assign rd_id   = owner;
   assign rd_last = rd_valid && (state == DRAIN);

endmodule

// File: tb/tb_rom_burst_ctrl.sv
// tb_rom_burst_ctrl: directed bench for rom_burst_ctrl with a behavioural ROM whose word at address a is 0x100+a.
// Expected grant order follows ROM_BURST_FIXED_PRIO_EN when that macro is defined for the build.
module tb_rom_burst_ctrl;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req0_valid = 1'b0;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_base = '0;
   logic [LEN_W-1:0]  req0_len = '0;
   logic              req1_valid = 1'b0;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_base = '0;
   logic [LEN_W-1:0]  req1_len = '0;
   logic              rom_read;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_dout = '0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_id;
   logic              rd_last;
   logic              cmd_done;
   logic              busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   rom_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_base(req0_base), .req0_len(req0_len),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_base(req1_base), .req1_len(req1_len),
      .rom_read(rom_read), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last),
      .cmd_done(cmd_done), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rom_read) rom_dout <= rom_word(rom_addr);
   end

   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return DATA_W'(16'h0100) + DATA_W'(a);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic id, input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
      if (id) begin
         req1_valid = 1'b1; req1_base = base; req1_len = len;
      end else begin
         req0_valid = 1'b1; req0_base = base; req0_len = len;
      end
   endtask

   // Issues one command, checks every cycle from acceptance to the idle cycle after DRAIN; called at a negedge.
   task automatic do_burst(input logic id, input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                           output int t_acc);
      int waited;
      int l;
      logic [ADDR_W-1:0] ea;
      l = int'(len);
      applyStimulus(id, base, len);
      #1;
      waited = 0;
      while (!(id ? req1_ready : req0_ready) && waited < 40) begin
         @(negedge clk); #1; waited++;
      end
      t_acc = cyc;
      checkOutput("accept", {31'b0, (id ? req1_ready : req0_ready)}, 32'd1);
      if (waited >= 40) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      for (int k = 1; k <= l + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end
         checkOutput("rom_read", {31'b0, rom_read}, {31'b0, (k <= l)});
         if (k <= l) begin
            ea = base + ADDR_W'(k - 1);
            checkOutput("rom_addr", {26'b0, rom_addr}, {26'b0, ea});
         end
         checkOutput("rd_valid", {31'b0, rd_valid}, {31'b0, (k >= 2)});
         if (k >= 2) begin
            ea = base + ADDR_W'(k - 2);
            checkOutput("rd_data", {16'b0, rd_data}, {16'b0, rom_word(ea)});
            checkOutput("rd_id", {31'b0, rd_id}, {31'b0, id});
         end else begin
            checkOutput("rd_data_gated", {16'b0, rd_data}, 32'd0);
         end
         checkOutput("rd_last", {31'b0, rd_last}, {31'b0, (l > 0 && k == l + 1)});
         checkOutput("cmd_done", {31'b0, cmd_done}, {31'b0, (k == l + 1)});
         if (k == l + 1) checkOutput("done_id", {31'b0, rd_id}, {31'b0, id});
         checkOutput("busy", {31'b0, busy}, 32'd1);
      end
      @(negedge clk);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);
      checkOutput("idle_read", {31'b0, rom_read}, 32'd0);
      checkOutput("idle_valid", {31'b0, rd_valid}, 32'd0);
      checkOutput("idle_done", {31'b0, cmd_done}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      int t1;
      int waited;
      int last_t;
      logic got_id;
      int exp_id[4];
      int exp_gap[4];
`ifdef ROM_BURST_FIXED_PRIO_EN
      exp_id  = '{0, 0, 0, 0};
      exp_gap = '{0, 9, 9, 9};
`else
      exp_id  = '{0, 1, 0, 1};
      exp_gap = '{0, 9, 7, 9};
`endif

      // Reset values, with a requester already valid while reset is held.
      applyStimulus(1'b0, 6'd0, 4'd7);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_ready0", {31'b0, req0_ready}, 32'd0);
      checkOutput("rst_read", {31'b0, rom_read}, 32'd0);
      checkOutput("rst_addr", {26'b0, rom_addr}, 32'd0);
      checkOutput("rst_valid", {31'b0, rd_valid}, 32'd0);
      checkOutput("rst_last", {31'b0, rd_last}, 32'd0);
      checkOutput("rst_done", {31'b0, cmd_done}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_data", {16'b0, rd_data}, 32'd0);
      checkOutput("rst_id", {31'b0, rd_id}, 32'd0);
      rst = 1'b0;

      $display("[TB] single burst and wrap");
      do_burst(1'b0, 6'd0, 4'd7, t0);
      do_burst(1'b1, 6'd60, 4'd6, t0);

      $display("[TB] zero length");
      do_burst(1'b0, 6'd33, 4'd0, t0);
      do_burst(1'b0, 6'd5, 4'd2, t1);
      checkOutput("zero_len_turnaround", t1 - t0, 32'd2);
      checkOutput("burst_turnaround", 32'(t1 - t0), 32'd2);

      $display("[TB] reset mid-burst");
      applyStimulus(1'b1, 6'd21, 4'd9);
      #1;
      waited = 0;
      while (!req1_ready && waited < 40) begin
         @(negedge clk); #1; waited++;
      end
      checkOutput("midrst_accept", {31'b0, req1_ready}, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) req1_valid = 1'b0;
         checkOutput("midrst_read", {31'b0, rom_read}, 32'd1);
         checkOutput("midrst_addr", {26'b0, rom_addr}, 32'(21 + k - 1));
      end
      @(negedge clk);
      req1_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_read_off", {31'b0, rom_read}, 32'd0);
      checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
      checkOutput("midrst_valid", {31'b0, rd_valid}, 32'd0);
      checkOutput("midrst_done", {31'b0, cmd_done}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("midrst_no_beat", {31'b0, rd_valid}, 32'd0);
         checkOutput("midrst_no_done", {31'b0, cmd_done}, 32'd0);
         checkOutput("midrst_no_read", {31'b0, rom_read}, 32'd0);
      end
      do_burst(1'b0, 6'd28, 4'd9, t0);

      $display("[TB] tie arbitration");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 6'd0, 4'd7);
      applyStimulus(1'b1, 6'd55, 4'd5);
      #1;
      last_t = 0;
      for (int g = 0; g < 4; g++) begin
         waited = 0;
         while (!(req0_ready || req1_ready) && waited < 40) begin
            @(negedge clk); #1; waited++;
         end
         checkOutput("tie_any_grant", {31'b0, (req0_ready || req1_ready)}, 32'd1);
         checkOutput("tie_one_grant", {31'b0, (req0_ready && req1_ready)}, 32'd0);
         got_id = req1_ready;
         checkOutput("tie_grant_id", {31'b0, got_id}, 32'(exp_id[g]));
         if (g > 0) checkOutput("tie_grant_gap", 32'(cyc - last_t), 32'(exp_gap[g]));
         last_t = cyc;
         @(negedge clk); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("tie_end_busy", {31'b0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rom_burst_ctrl.md
# rom_burst_ctrl

Read sequencer and arbiter in front of the weight/ifmap `rom`. It accepts burst-read commands (base address, word count) from two requesters: requester 0 is the filter loader and requester 1 is the ifmap loader. It grants one command at a time and drives the ROM `read`/`addr` pins with consecutive addresses. It returns the ROM data stream tagged with requester ID, last-beat flag and a command-done pulse.

## Interface
- `ADDR_W`, default 6: ROM address width.
- `DATA_W`, default 16: ROM data width.
- `LEN_W`, default 4: burst length field width (0..15 words).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 command valid.
- `req0_ready` output 1: requester 0 command accepted on this edge when high with valid.
- `req0_base` input ADDR_W: requester 0 start address.
- `req0_len` input LEN_W: requester 0 word count.
- `req1_valid`, `req1_ready`, `req1_base`, `req1_len`: same fields for requester 1.
- `rom_read` output 1: ROM read enable.
- `rom_addr` output ADDR_W: ROM address.
- `rom_dout` input DATA_W: ROM data. The ROM registers it on the edge where `read`=1, so it is valid the following cycle.
- `rd_valid` output 1: data beat valid.
- `rd_data` output DATA_W: equals `rom_dout` when `rd_valid`=1, else 0.
- `rd_id` output 1: owner of the current beat or done pulse.
- `rd_last` output 1: final beat of the burst.
- `cmd_done` output 1: one-cycle pulse at command completion.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, ISSUE and DRAIN.
- IDLE:
  - `reqN_ready` is combinational: high only for the granted requester, and only while its valid is high.
  - On acceptance, latch base, len and id.
  - If len>0, go to ISSUE; if len=0, go to DRAIN.
- ISSUE:
  - Drive `rom_read`=1 and `rom_addr`=base+k for k=0..len-1, one address per cycle.
  - Address arithmetic is modulo 2^ADDR_W. Example: base 62, len 4 gives addresses 62, 63, 0, 1.
  - After issuing address len-1, go to DRAIN.
- DRAIN: lasts one cycle, during which the last beat returns. Then go to IDLE.
- Arbitration is round-robin:
  - If only one requester is valid, it wins.
  - If both are valid, the one not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
- No read-data backpressure: consumers accept every beat.
- `rom_read`=0 outside ISSUE; `rom_addr` holds its last value.
- A zero-length command produces no ROM reads and no beats. It produces only `cmd_done` (with `rd_id`) in its DRAIN cycle; `rd_last` stays 0.
- Command inputs are ignored outside IDLE. Requesters hold valid and fields until ready.

## Timing
- Accept edge at cycle T, len=L>0:
  - `rom_read` high in cycles T+1..T+L.
  - `rd_valid` high in cycles T+2..T+L+1.
  - `rd_last` and `cmd_done` are high in cycle T+L+1.
  - Earliest next accept edge is T+L+2.
- For len=0: `cmd_done` in cycle T+1; next accept edge is T+2.
- Burst throughput: one word per cycle. Turnaround overhead is 2 idle cycles per command.
- Reset values:
  - State IDLE; pointer=1.
  - `rom_read`=0, `rom_addr`=0.
  - `rd_valid`, `rd_last`, `cmd_done`, `busy` all 0.
  - `rd_data`=0, `rd_id`=0.
  - Both `reqN_ready` are forced 0 while `rst`=1.
- Reset mid-burst: on the next edge, state returns to IDLE and `rom_read`=0. The in-flight ROM word is discarded: `rd_valid` stays 0 and no `cmd_done` is issued.
- Valid asserted in the same cycle as reset deassertion: it can be accepted no earlier than the first edge after `rst` is low.

## Configuration
- `ROM_BURST_FIXED_PRIO_EN` defined: fixed priority, requester 0 always wins ties. The pointer is not implemented.
- Not defined: round-robin as described above.

## Test plan
- **Single burst.** Req0 base 0, len 7, accept at T.
  - Addresses 0..6 in T+1..T+7.
  - `rd_valid` T+2..T+8 with ROM words 0..6, `rd_id`=0.
  - `rd_last` and `cmd_done` at T+8.
- **Wrap.** Req1 base 60, len 6.
  - Addresses 60, 61, 62, 63, 0, 1.
  - 6 beats with `rd_id`=1, `rd_last` on the sixth.
- **Tie arbitration.**
  - Both valid continuously: req0 {0,7}, req1 {55,5}. Grants alternate 0,1,0,1.
  - The second grant is accepted at T+9 after the first 7-word burst.
  - With `ROM_BURST_FIXED_PRIO_EN` defined, grants are 0,0,0.
- **Zero length.** Req0 len 0.
  - `rom_read` never high, no `rd_valid`.
  - `cmd_done`=1, `rd_id`=0 at T+1; ready again at T+2.
- **Reset mid-burst.** Req1 base 21, len 9, `rst` pulsed during cycle T+4.
  - Next cycle: `rom_read`=0, `busy`=0, no further beats, no `cmd_done`.
  - A following req0 base 28, len 9 completes normally.
